counter_modn_cascade: RTL and testbench
=======================================

# counter_modn_cascade

Parametrised multi-digit modulo-RADIX up/down counter with synchronous load, count enable and a cascadable terminal-count carry. It generalises the single-digit decade counter to DIGITS digits of arbitrary radix with a selectable direction. It is used as a timebase and event counter and chains with further instances through `carry`.

## Interface
- `RADIX`, default 10: modulus of each digit, at least 2.
- `DIGITS`, default 2: number of cascaded digits, at least 1.
- `DW`, default $clog2(RADIX): bits per digit (derived, not overridden).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; clears all state immediately on assertion.
- `en` in 1: count enable; a step occurs on each rising edge while high.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `load` in 1: synchronous load of `load_val`; has priority over `en`.
- `load_val` in DIGITS*DW: load value; digit k occupies bits [k*DW +: DW], with digit 0 as the least significant.
- `count` out DIGITS*DW: registered counter value, packed the same way as `load_val`.
- `carry` out 1: combinational terminal-count flag for cascading.
- `overflow` out 1: registered sticky wrap flag.

## Operation
- **Reset (`reset`=0):**
  - `count` = 0 and `overflow` = 0, asynchronously.
  - `carry` follows its combinational equation from the reset value.
- **Priority each edge:** load > enable > hold.
- **Load:**
  - Each loaded digit = min(load_val digit, RADIX-1); out-of-range digits clamp to RADIX-1.
  - `overflow` is cleared on load.
- **Up step:**
  - Digit 0 increments.
  - A digit at RADIX-1 wraps to 0 and increments the next digit (ripple within the same edge).
- **Down step:**
  - Digit 0 decrements.
  - A digit at 0 wraps to RADIX-1 and decrements the next digit.
- **Terminal count:**
  - Up: all digits = RADIX-1.
  - Down: all digits = 0.
- **`carry`:** = `en` & !`load` & terminal count. It is high in the cycle whose edge wraps the whole counter, so it can drive the `en` of a downstream instance sharing the same `up`.
- **Full wrap:**
  - Counter becomes all-0 (up) or all RADIX-1 (down).
  - `overflow` is set and stays set until load or reset.
- **Direction:** a change of `up` takes effect on the next step with no extra latency. Reversing at the terminal value does not wrap.
- **`en`=0, `load`=0:** all state holds.

## Timing
- `count` updates 1 cycle after an edge sampling `load`=1 or `en`=1.
- No pipeline; the ripple across digits completes in one cycle.
- `carry` has 0 latency (combinational from `count`, `en`, `load`, `up`). It must not be registered.
- `overflow` rises on the same edge that performs the full wrap.
- **Reset deasserted mid-cycle:** counting begins at the first rising edge with `reset`=1. No step is lost or duplicated beyond that edge.
- **Reset asserted during load or step:** reset wins. `count` = 0 within the assertion, with no clock edge required.
- **`load` and `en` high together:** load only; no step, and `carry` = 0.

## Structure
- **Shared package `counter_pkg`:**
  - `function clog2_min1` (returns ≥ 1).
  - `localparam` for default RADIX/DIGITS.
  - Direction constants `CNT_UP` = 1, `CNT_DOWN` = 0.
- **Sub-module `counter_digit`:**
  - Parameter: RADIX.
  - Ports: clk, reset, `load`, `load_d`, `step`, `up`, `q`, `tc`.
  - `tc` = terminal value for the current direction.
  - The top generates DIGITS instances. `step`[k] = `en` & !`load` & AND of `tc`[0..k-1].
- **Top:** computes `carry` = `en` & !`load` & AND of all `tc`, plus the `overflow` register.

## Test plan
All scenarios use RADIX=10, DIGITS=2 unless noted.
- **Reset:** `reset`=0 with `en`=1 for 2 cycles → `count`=0x00, `overflow`=0. Release, 5 enabled edges up → `count`=0x05.
- **Up wrap:** load 0x98, `en`=1, `up`=1 → `count` steps 0x99 then 0x00. `carry`=1 only during the 0x99 cycle. `overflow`=1 from 0x00 onward.
- **Down wrap:** load 0x01, `up`=0 → `count` steps 0x00 then 0x99. `carry` is high during the 0x00 cycle only.
- **Load priority and clamp:** `load`=1, `en`=1, `load_val`=0xC3 → `count`=0x93, `overflow` cleared, `carry`=0 that cycle.
- **Enable gating and direction change:**
  - From 0x09 up, hold `en`=0 for 3 cycles → `count` stays 0x09.
  - Then up 1 step → 0x10.
  - Then down 1 step → 0x09 (digit borrow).
- **Mid-operation reset and cascade:**
  - Two instances with RADIX=6, DIGITS=1; the second's `en` = first's `carry`.
  - 13 enabled edges from 0 → counts 1 and 2.
  - Assert `reset` asynchronously between edges → both are 0 before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N cascade counter.
package counter_pkg;

  localparam int unsigned DefaultRadix  = 10;
  localparam int unsigned DefaultDigits = 2;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Digit width that never collapses to zero bits, even for RADIX = 2.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-RADIX up/down digit with clamped synchronous load and a
// direction-aware terminal-count flag.
module counter_digit
  import counter_pkg::*;
#(
  parameter  int unsigned RADIX = DefaultRadix,
  localparam int unsigned DW    = clog2_min1(RADIX)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_d,
  input  logic          i_step,
  input  logic          i_up,
  output logic [DW-1:0] o_q,
  output logic          o_tc
);

  localparam logic [DW-1:0] MaxVal = DW'(RADIX - 1);

  logic [DW-1:0] r_q;
  logic [DW-1:0] w_q_d;
  logic [DW-1:0] w_load_clamped;
  logic          w_is_max;
  logic          w_is_zero;

  assign w_is_max       = (r_q == MaxVal);
  assign w_is_zero      = (r_q == '0);
  assign w_load_clamped = (i_load_d > MaxVal) ? MaxVal : i_load_d;

  always_comb begin
    w_q_d = r_q;
    if (i_load) begin
      w_q_d = w_load_clamped;
    end else if (i_step) begin
      if (i_up == CNT_UP) begin
        w_q_d = w_is_max ? '0 : r_q + DW'(1);
      end else begin
        w_q_d = w_is_zero ? MaxVal : r_q - DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_d;
    end
  end

  assign o_q  = r_q;
  assign o_tc = (i_up == CNT_UP) ? w_is_max : w_is_zero;

endmodule

// File: rtl/counter_modn_cascade.sv
// DIGITS-digit modulo-RADIX up/down counter with load, enable, a
// combinational cascade carry and a sticky full-wrap overflow flag.
module counter_modn_cascade
  import counter_pkg::*;
#(
  parameter  int unsigned RADIX  = DefaultRadix,
  parameter  int unsigned DIGITS = DefaultDigits,
  localparam int unsigned DW     = clog2_min1(RADIX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_up,
  input  logic                 i_load,
  input  logic [DIGITS*DW-1:0] i_load_val,
  output logic [DIGITS*DW-1:0] o_count,
  output logic                 o_carry,
  output logic                 o_overflow
);

  logic              w_active;
  logic [DIGITS-1:0] w_tc;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS:0]   w_tc_prefix;
  logic              r_overflow;

  assign w_active       = i_en & ~i_load;
  assign w_tc_prefix[0] = 1'b1;

  // Each digit steps when all lower digits sit at their terminal value.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_tc_prefix[k+1] = w_tc_prefix[k] & w_tc[k];
    assign w_step[k]        = w_active & w_tc_prefix[k];

    counter_digit #(
      .RADIX (RADIX)
    ) u_digit (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (i_load),
      .i_load_d (i_load_val[k*DW +: DW]),
      .i_step   (w_step[k]),
      .i_up     (i_up),
      .o_q      (o_count[k*DW +: DW]),
      .o_tc     (w_tc[k])
    );
  end

  assign o_carry = w_active & w_tc_prefix[DIGITS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_load) begin
      r_overflow <= 1'b0;
    end else if (o_carry) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_counter_modn_cascade.sv
// Scoreboard bench: integer-valued reference model feeds an expectation
// queue; a negedge monitor pops and compares against the DUT.
module tb_counter_modn_cascade;

  localparam int unsigned Radix  = 10;
  localparam int unsigned Digits = 2;
  localparam int unsigned Dw     = $clog2(Radix);
  localparam int unsigned W      = Digits * Dw;
  localparam int unsigned Mod    = Radix ** Digits;

  typedef struct {
    logic [W-1:0] count;
    logic         ovf;
    logic         carry;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         carry;
  logic         overflow;

  logic         c_rst_n;
  logic         c_en;
  logic [2:0]   c0_count;
  logic [2:0]   c1_count;
  logic         c0_carry;
  logic         c1_carry;
  logic         c0_ovf;
  logic         c1_ovf;

  exp_t         sb[$];
  int unsigned  m_val;
  bit           m_ovf;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  counter_modn_cascade #(
    .RADIX  (Radix),
    .DIGITS (Digits)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_load     (load),
    .i_load_val (load_val),
    .o_count    (count),
    .o_carry    (carry),
    .o_overflow (overflow)
  );

  counter_modn_cascade #(
    .RADIX  (6),
    .DIGITS (1)
  ) u_c0 (
    .i_clk      (clk),
    .i_rst_n    (c_rst_n),
    .i_en       (c_en),
    .i_up       (1'b1),
    .i_load     (1'b0),
    .i_load_val (3'd0),
    .o_count    (c0_count),
    .o_carry    (c0_carry),
    .o_overflow (c0_ovf)
  );

  counter_modn_cascade #(
    .RADIX  (6),
    .DIGITS (1)
  ) u_c1 (
    .i_clk      (clk),
    .i_rst_n    (c_rst_n),
    .i_en       (c0_carry),
    .i_up       (1'b1),
    .i_load     (1'b0),
    .i_load_val (3'd0),
    .o_count    (c1_count),
    .o_carry    (c1_carry),
    .o_overflow (c1_ovf)
  );

  function automatic logic [W-1:0] encode(input int unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < Digits; k++) r[k*Dw +: Dw] = Dw'((v / (Radix ** k)) % Radix);
    return r;
  endfunction

  function automatic int unsigned decode_clamp(input logic [W-1:0] lv);
    int unsigned v;
    int unsigned d;
    v = 0;
    for (int k = 0; k < Digits; k++) begin
      d = int'(lv[k*Dw +: Dw]);
      if (d > Radix - 1) d = Radix - 1;
      v += d * (Radix ** k);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge; model advances on the edge.
  task automatic cycle(input bit e, input bit u, input bit l, input logic [W-1:0] lv);
    exp_t x;
    bit   term;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    term     = u ? (m_val == Mod - 1) : (m_val == 0);
    x.count  = encode(m_val);
    x.ovf    = m_ovf;
    x.carry  = e & ~l & term;
    sb.push_back(x);
    @(posedge clk);
    if (!rst_n) begin
      m_val = 0;
      m_ovf = 0;
    end else if (l) begin
      m_val = decode_clamp(lv);
      m_ovf = 0;
    end else if (e) begin
      if (term) m_ovf = 1;
      m_val = u ? (m_val + 1) % Mod : (m_val + Mod - 1) % Mod;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("count", 32'(count), 32'(x.count));
      check("overflow", 32'(overflow), 32'(x.ovf));
      check("carry", 32'(carry), 32'(x.carry));
    end
  end

  initial begin
    logic [W-1:0] lv;
    int unsigned  pick;
    rst_n = 1'b0; c_rst_n = 1'b0; c_en = 1'b0;
    en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    m_val = 0; m_ovf = 0;
    @(posedge clk); #1;

    // Reset held with enable high, then five up steps.
    cycle(1, 1, 0, '0);
    cycle(1, 1, 0, '0);
    rst_n = 1'b1; c_rst_n = 1'b1;
    repeat (5) cycle(1, 1, 0, '0);
    cycle(0, 1, 0, '0);

    // Up wrap from 0x98.
    cycle(0, 1, 1, 8'h98);
    cycle(1, 1, 0, '0);
    cycle(1, 1, 0, '0);
    cycle(0, 1, 0, '0);

    // Down wrap from 0x01.
    cycle(0, 0, 1, 8'h01);
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);

    // Load beats enable at the terminal value; high nibble clamps to 9.
    cycle(1, 1, 0, '0);
    cycle(0, 1, 1, 8'h99);
    cycle(1, 1, 1, 8'hC3);
    cycle(0, 1, 0, '0);

    // Enable gating, then up across a digit boundary and back down.
    cycle(0, 1, 1, 8'h09);
    repeat (3) cycle(0, 1, 0, '0);
    cycle(1, 1, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);

    // Asynchronous reset between edges on a nonzero count.
    cycle(0, 1, 1, 8'h57);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_ovf", 32'(overflow), 32'h0);
    m_val = 0; m_ovf = 0;
    @(posedge clk); #1;
    cycle(1, 1, 0, '0);
    rst_n = 1'b1;
    cycle(1, 1, 0, '0);

    // Randomised run, biased toward loads near the wrap points.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: lv = 8'h98;
        1: lv = 8'h01;
        2: lv = 8'h99;
        default: lv = 8'($urandom);
      endcase
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) == 0), lv);
    end
    cycle(0, 1, 0, '0);
    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'h0);

    // Two RADIX=6 instances chained through carry.
    @(posedge clk); #1;
    c_en = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    c_en = 1'b0;
    check("cas_c0", 32'(c0_count), 32'(13 % 6));
    check("cas_c1", 32'(c1_count), 32'(13 / 6));
    check("cas_c0_ovf", 32'(c0_ovf), 32'h1);
    @(negedge clk); #2;
    c_rst_n = 1'b0;
    #1;
    check("cas_rst_c0", 32'(c0_count), 32'h0);
    check("cas_rst_c1", 32'(c1_count), 32'h0);
    check("cas_rst_ovf", 32'(c0_ovf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
